// File: rtl/hex_display_controller.sv
// Two-digit 7-segment hex display driver: decodes an 8-bit value to a 16-bit
// segment frame and shifts it MSB-first onto the sclk/sdo/latch chain.
module hex_display_controller #(
  parameter int unsigned CLK_DIV        = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       gclk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic [1:0] dp,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic       hex_sclk,
  output logic       hex_sdo,
  output logic       hex_latch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_LATCH,
    S_DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_frame;
  logic [7:0]  r_pend_val;
  logic [1:0]  r_pend_dp;
  logic        r_pending;
  logic [7:0]  r_div;
  logic [4:0]  r_bits;

  logic        w_div_end;
  logic        w_start;
  logic [7:0]  w_src_val;
  logic [1:0]  w_src_dp;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  function automatic logic [15:0] build_frame(input logic [7:0] v, input logic [1:0] d);
    logic [15:0] f;
    f = {d[1], seg7(v[7:4]), d[0], seg7(v[3:0])};
    return SEG_ACTIVE_LOW ? ~f : f;
  endfunction

  assign w_div_end = (r_div == DIV_LAST);

  // A load seen in DONE supersedes any older pending request.
  always_comb begin
    w_src_val = value;
    w_src_dp  = dp;
    if (r_state == S_DONE && !load) begin
      w_src_val = r_pend_val;
      w_src_dp  = r_pend_dp;
    end
  end

  assign w_start = ((r_state == S_IDLE) && load) ||
                   ((r_state == S_DONE) && (load || r_pending));

  always_ff @(posedge gclk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (load) w_next = S_LOW;
      S_LOW:   if (w_div_end) w_next = S_HIGH;
      S_HIGH:  if (w_div_end) w_next = (r_bits == 5'd15) ? S_LATCH : S_LOW;
      S_LATCH: if (w_div_end) w_next = S_DONE;
      S_DONE:  w_next = w_start ? S_LOW : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    hex_sclk  = (r_state == S_HIGH);
    hex_latch = (r_state == S_LATCH);
    hex_sdo   = ((r_state == S_LOW) || (r_state == S_HIGH)) ? r_frame[15] : 1'b0;
  end

  always_ff @(posedge gclk) begin
    if (reset) begin
      r_frame    <= '0;
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pending  <= 1'b0;
      r_div      <= '0;
      r_bits     <= '0;
    end else begin
      if (w_next != r_state || r_state == S_IDLE || r_state == S_DONE) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 8'd1;
      end

      if (w_start) begin
        r_frame <= build_frame(w_src_val, w_src_dp);
        r_bits  <= '0;
      end else if (r_state == S_HIGH && w_div_end) begin
        r_bits <= r_bits + 5'd1;
        if (r_bits != 5'd15) begin
          r_frame <= {r_frame[14:0], 1'b0};
        end
      end

      if (r_state == S_DONE) begin
        r_pending <= 1'b0;
      end else if (load && r_state != S_IDLE) begin
        r_pending  <= 1'b1;
        r_pend_val <= value;
        r_pend_dp  <= dp;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_controller.sv
// Bench for hex_display_controller: three instances (div 4, div 4 inverted,
// div 1) checked from a serial-chain monitor against a frame reference model.
module tb_hex_display_controller;

  logic       gclk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] value = '0;
  logic [1:0] dp = '0;
  logic [2:0] ld = '0;
  logic [2:0] busy, done, sclk, sdo, latch;

  always #5 gclk = ~gclk;

  int cyc = 0;
  always @(posedge gclk) cyc <= cyc + 1;

  hex_display_controller #(.CLK_DIV(4), .SEG_ACTIVE_LOW(1'b0)) u_div4 (
    .gclk(gclk), .reset(reset), .value(value), .dp(dp), .load(ld[0]),
    .busy(busy[0]), .done(done[0]), .hex_sclk(sclk[0]), .hex_sdo(sdo[0]), .hex_latch(latch[0]));
  hex_display_controller #(.CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1)) u_inv (
    .gclk(gclk), .reset(reset), .value(value), .dp(dp), .load(ld[1]),
    .busy(busy[1]), .done(done[1]), .hex_sclk(sclk[1]), .hex_sdo(sdo[1]), .hex_latch(latch[1]));
  hex_display_controller #(.CLK_DIV(1), .SEG_ACTIVE_LOW(1'b0)) u_div1 (
    .gclk(gclk), .reset(reset), .value(value), .dp(dp), .load(ld[2]),
    .busy(busy[2]), .done(done[2]), .hex_sclk(sclk[2]), .hex_sdo(sdo[2]), .hex_latch(latch[2]));

  int DIV[3] = '{4, 4, 1};
  bit INV[3] = '{1'b0, 1'b1, 1'b0};

  localparam logic [6:0] SEG_TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [15:0] ref_frame(input logic [7:0] v, input logic [1:0] d, input bit inv);
    logic [15:0] f;
    f = {d[1], SEG_TBL[v[7:4]], d[0], SEG_TBL[v[3:0]]};
    return inv ? ~f : f;
  endfunction

  // Serial-chain monitor: reconstructs each frame from sdo at sclk rises.
  logic [15:0] shreg[3]       = '{16'h0, 16'h0, 16'h0};
  logic        prev_sclk[3]   = '{1'b0, 1'b0, 1'b0};
  logic        prev_sdo[3]    = '{1'b0, 1'b0, 1'b0};
  int          rises[3]       = '{0, 0, 0};
  int          lat[3]         = '{0, 0, 0};
  int          latch_total[3] = '{0, 0, 0};
  int          busy_low[3]    = '{0, 0, 0};
  int          sdo_viol[3]    = '{0, 0, 0};
  int          obs_n[3]       = '{0, 0, 0};
  logic [15:0] obs_frame[3][8];
  int          obs_rises[3][8];
  int          obs_lat[3][8];
  int          obs_dcyc[3][8];

  always @(negedge gclk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        rises[i] = 0; lat[i] = 0; shreg[i] = '0; prev_sclk[i] = 1'b0; prev_sdo[i] = 1'b0;
      end else begin
        if (sclk[i] && !prev_sclk[i]) begin
          shreg[i] = {shreg[i][14:0], sdo[i]};
          rises[i]++;
        end
        if (sclk[i] && prev_sclk[i] && sdo[i] !== prev_sdo[i]) sdo_viol[i]++;
        if (latch[i]) begin
          lat[i]++;
          latch_total[i]++;
          if (sdo[i] !== 1'b0) sdo_viol[i]++;
        end
        if (done[i]) begin
          obs_frame[i][obs_n[i] % 8] = shreg[i];
          obs_rises[i][obs_n[i] % 8] = rises[i];
          obs_lat[i][obs_n[i] % 8]   = lat[i];
          obs_dcyc[i][obs_n[i] % 8]  = cyc;
          obs_n[i]++;
          rises[i] = 0;
          lat[i] = 0;
        end
        if (!busy[i]) busy_low[i]++;
        prev_sclk[i] = sclk[i];
        prev_sdo[i] = sdo[i];
      end
    end
  end

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge gclk);
    #1;
  endtask

  task automatic wait_done(input int i, input int target, input int budget);
    int k = 0;
    while (obs_n[i] < target && k < budget) begin
      step();
      k++;
    end
    chk($sformatf("wait_done_inst%0d", i), 32'(obs_n[i] >= target), 32'd1);
  endtask

  task automatic run_frame(input int i, input logic [7:0] v, input logic [1:0] d,
                           input logic [15:0] exp, input string nm);
    int base, n, k;
    base = obs_n[i];
    value = v; dp = d; ld[i] = 1'b1;
    n = cyc;
    step();
    ld[i] = 1'b0;
    chk({nm, "_busy_rise"}, 32'(busy[i]), 32'd1);
    chk({nm, "_first_bit"}, 32'(sdo[i]), 32'(exp[15]));
    wait_done(i, base + 1, 33 * DIV[i] + 20);
    if (obs_n[i] > base) begin
      k = base % 8;
      chk({nm, "_frame"}, 32'(obs_frame[i][k]), 32'(exp));
      chk({nm, "_rises"}, 32'(obs_rises[i][k]), 32'd16);
      chk({nm, "_latch_len"}, 32'(obs_lat[i][k]), 32'(DIV[i]));
      chk({nm, "_done_cycle"}, 32'(obs_dcyc[i][k] - n), 32'(1 + 33 * DIV[i]));
    end
    step();
    chk({nm, "_busy_fall"}, 32'(busy[i]), 32'd0);
  endtask

  typedef struct {
    int          inst;
    logic [7:0]  v;
    logic [1:0]  d;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int base, bl, lt, on, k, d1;
    logic [7:0] rv;
    logic [1:0] rd;
    int ri;

    vecs[0] = '{0, 8'h3A, 2'b00, 16'h4F77};
    vecs[1] = '{0, 8'h80, 2'b10, 16'hFF3F};
    vecs[2] = '{1, 8'h80, 2'b10, 16'h00C0};
    vecs[3] = '{2, 8'h09, 2'b00, 16'h3F6F};
    vecs[4] = '{0, 8'hFF, 2'b11, 16'hF1F1};
    vecs[5] = '{1, 8'h00, 2'b01, 16'hC040};
    vecs[6] = '{2, 8'hB4, 2'b10, 16'hFC66};

    // Reset held with load high: nothing may start.
    ld = '1; value = 8'hFF;
    repeat (3) begin
      step();
      chk("reset_outputs", 32'({busy, done, sclk, sdo, latch}), 32'd0);
    end
    reset = 1'b0; ld = '0;
    repeat (4) step();
    chk("idle_after_reset", 32'(busy), 32'd0);

    for (int t = 0; t < 7; t++)
      run_frame(vecs[t].inst, vecs[t].v, vecs[t].d, vecs[t].exp, $sformatf("vec%0d", t));

    // Pending, last wins, back-to-back with continuous busy.
    base = obs_n[0]; bl = busy_low[0];
    value = 8'h12; dp = 2'b00; ld[0] = 1'b1; step(); ld[0] = 1'b0;
    repeat (5) step();
    value = 8'h34; ld[0] = 1'b1; step(); ld[0] = 1'b0;
    repeat (5) step();
    value = 8'h56; ld[0] = 1'b1; step(); ld[0] = 1'b0;
    wait_done(0, base + 2, 400);
    chk("pend_frame1", 32'(obs_frame[0][base % 8]), 32'h065B);
    chk("pend_frame2", 32'(obs_frame[0][(base + 1) % 8]), 32'h6D7D);
    chk("pend_period", 32'(obs_dcyc[0][(base + 1) % 8] - obs_dcyc[0][base % 8]), 32'd133);
    chk("pend_busy_gap", 32'(busy_low[0] - bl), 32'd0);
    repeat (3) step();
    chk("pend_no_third", 32'(obs_n[0] - base), 32'd2);
    chk("pend_busy_fall", 32'(busy[0]), 32'd0);

    // Load arriving in the DONE cycle starts the next frame immediately.
    base = obs_n[2];
    value = 8'h21; dp = 2'b00; ld[2] = 1'b1; step(); ld[2] = 1'b0;
    k = 0;
    while (!done[2] && k < 100) begin step(); k++; end
    chk("dload_done_seen", 32'(done[2]), 32'd1);
    value = 8'hE7; dp = 2'b01; ld[2] = 1'b1; step(); ld[2] = 1'b0;
    wait_done(2, base + 2, 100);
    chk("dload_frame1", 32'(obs_frame[2][base % 8]), 32'h5B06);
    chk("dload_frame2", 32'(obs_frame[2][(base + 1) % 8]), 32'h7987);
    chk("dload_period", 32'(obs_dcyc[2][(base + 1) % 8] - obs_dcyc[2][base % 8]), 32'd34);

    // Reset after the 7th rise: no latch, no done, then a clean frame.
    repeat (3) step();
    value = 8'h5C; dp = 2'b11; ld[0] = 1'b1; step(); ld[0] = 1'b0;
    k = 0;
    while (rises[0] < 7 && k < 200) begin step(); k++; end
    chk("midrst_rises", 32'(rises[0]), 32'd7);
    reset = 1'b1;
    step();
    chk("midrst_outputs", 32'({busy[0], done[0], sclk[0], sdo[0], latch[0]}), 32'd0);
    reset = 1'b0;
    lt = latch_total[0]; on = obs_n[0];
    repeat (150) step();
    chk("midrst_no_latch", 32'(latch_total[0] - lt), 32'd0);
    chk("midrst_no_done", 32'(obs_n[0] - on), 32'd0);
    chk("midrst_idle", 32'(busy[0]), 32'd0);
    run_frame(0, 8'hFF, 2'b00, 16'h7171, "after_reset");

    for (int r = 0; r < 12; r++) begin
      ri = int'($urandom_range(0, 2));
      rv = 8'($urandom);
      rd = 2'($urandom);
      run_frame(ri, rv, rd, ref_frame(rv, rd, INV[ri]), $sformatf("rand%0d", r));
    end

    for (int i = 0; i < 3; i++)
      chk($sformatf("sdo_stability_inst%0d", i), 32'(sdo_viol[i]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

endmodule
